// File: rtl/spi_clk_scheduler.sv
// spi_clk_scheduler: round-robin owner of one shared clock_divider.
// Define SPI_CLK_SCHED_DIV_CHECK_EN to reject zero or odd divisors.
module spi_clk_scheduler #(
    parameter int N_REQ = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [N_REQ*8-1:0] i_div,
    output logic [N_REQ-1:0]   o_grant,
    output logic [N_REQ-1:0]   o_done,
    output logic [N_REQ-1:0]   o_err,
    output logic               o_busy,
    output logic [8:0]         o_div_config,
    output logic               o_div_start_n,
    input  logic               i_div_ready
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        CONFIG,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        DONE
`ifdef SPI_CLK_SCHED_DIV_CHECK_EN
        , ERR
`endif
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   win_q;
    logic [IW-1:0]   last_q;
    logic [7:0]      div_q;
    logic [N_REQ-1:0] grant_q;
    logic [N_REQ-1:0] done_q;
    logic            busy_q;
    logic [8:0]      cfg_q;
    logic            start_n_q;

    logic [IW-1:0]   win_d;
    logic [IW-1:0]   idx;
    logic            found_d;
    logic [N_REQ-1:0] win_oh;
    logic [7:0]      div_a [N_REQ];

    for (genvar k = 0; k < N_REQ; k++) begin : g_div
        assign div_a[k] = i_div[8*k +: 8];
    end

    // First asserted request strictly after the last owner, wrapping.
    always_comb begin
        found_d = 1'b0;
        win_d   = '0;
        idx     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = IW'((int'(last_q) + i) % N_REQ);
            if (!found_d && i_req[idx]) begin
                found_d = 1'b1;
                win_d   = idx;
            end
        end
    end

    assign win_oh = N_REQ'(1) << win_q;

`ifdef SPI_CLK_SCHED_DIV_CHECK_EN
    logic [N_REQ-1:0] err_q;
    assign o_err = err_q;
`else
    assign o_err = '0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            win_q     <= '0;
            last_q    <= IW'(N_REQ - 1);
            div_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
            cfg_q     <= '0;
            start_n_q <= 1'b1;
`ifdef SPI_CLK_SCHED_DIV_CHECK_EN
            err_q     <= '0;
`endif
        end else begin
            done_q    <= '0;
            cfg_q     <= '0;
            start_n_q <= 1'b1;
`ifdef SPI_CLK_SCHED_DIV_CHECK_EN
            err_q     <= '0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (found_d && i_div_ready) begin
                        win_q   <= win_d;
                        div_q   <= div_a[win_d];
                        busy_q  <= 1'b1;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
`ifdef SPI_CLK_SCHED_DIV_CHECK_EN
                    if (div_q == 8'd0 || div_q[0]) begin
                        err_q   <= win_oh;
                        state_q <= ERR;
                    end else begin
                        grant_q <= win_oh;
                        cfg_q   <= {div_q, 1'b1};
                        state_q <= CONFIG;
                    end
`else
                    grant_q <= win_oh;
                    cfg_q   <= {div_q, 1'b1};
                    state_q <= CONFIG;
`endif
                end
                CONFIG: begin
                    start_n_q <= 1'b0;
                    state_q   <= START;
                end
                START: state_q <= WAIT_BUSY;
                WAIT_BUSY: begin
                    if (!i_div_ready) state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (i_div_ready) begin
                        done_q  <= win_oh;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    last_q  <= win_q;
                    state_q <= IDLE;
                end
`ifdef SPI_CLK_SCHED_DIV_CHECK_EN
                ERR: begin
                    busy_q  <= 1'b0;
                    last_q  <= win_q;
                    state_q <= IDLE;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_grant       = grant_q;
    assign o_done        = done_q;
    assign o_busy        = busy_q;
    assign o_div_config  = cfg_q;
    assign o_div_start_n = start_n_q;

endmodule

// File: tb/tb_spi_clk_scheduler.sv
// tb_spi_clk_scheduler: directed stimulus, divider stub and a
// cycle-count model of the scheduler compared every cycle.
module tb_spi_clk_scheduler;

    localparam int N = 2;
    localparam int BURST = 6;
`ifdef SPI_CLK_SCHED_DIV_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*8-1:0] div;
    logic           ready;
    logic [N-1:0]   o_grant;
    logic [N-1:0]   o_done;
    logic [N-1:0]   o_err;
    logic           o_busy;
    logic [8:0]     o_div_config;
    logic           o_div_start_n;

    int n_pass = 0;
    int n_total = 0;

    spi_clk_scheduler #(.N_REQ(N)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req        (req),
        .i_div        (div),
        .o_grant      (o_grant),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_busy       (o_busy),
        .o_div_config (o_div_config),
        .o_div_start_n(o_div_start_n),
        .i_div_ready  (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      nm, act, exp, $time);
    endtask

    // Divider stub: ready drops two cycles after start, low for BURST cycles.
    initial begin
        int cnt;
        cnt = 0;
        ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ready = 1'b1;
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                ready = (cnt == 0) || (cnt > BURST);
            end else if (!o_div_start_n) begin
                cnt = BURST + 2;
            end
        end
    end

    // Model: transaction age m_t counts cycles since the request was taken.
    int         m_own = -1;
    int         m_last = N - 1;
    int         m_t = 0;
    bit         m_lo = 0;
    bit         m_fin = 0;
    bit         m_valid = 0;
    logic [7:0] m_div = '0;

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++)
            if (r[(last + i) % N]) return (last + i) % N;
        return -1;
    endfunction

    function automatic bit m_bad();
        return (CHK == 1) && (m_div == 8'd0 || m_div[0]);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            m_valid = 1;
            if (!rst_n) begin
                m_own = -1; m_last = N - 1; m_t = 0;
                m_lo = 0; m_fin = 0;
            end else if (m_own < 0) begin
                if (req != '0 && ready) begin
                    m_own = rr_pick(req, m_last);
                    m_div = div[m_own*8 +: 8];
                    m_t = 1; m_lo = 0; m_fin = 0;
                end
            end else if (m_fin || (m_bad() && m_t == 2)) begin
                m_last = m_own;
                m_own = -1;
                m_fin = 0;
            end else begin
                if (m_t >= 4) begin
                    if (!m_lo) m_lo = !ready;
                    else if (ready) m_fin = 1;
                end
                m_t++;
            end
        end
    end

    // Per-cycle compare of every output against the model.
    initial begin
        logic [N-1:0] oh;
        bit act;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                act = (m_own >= 0);
                oh = act ? (N'(1) << m_own) : '0;
                check("busy", o_busy, act);
                check("grant", o_grant,
                      (act && !m_bad() && m_t >= 2) ? oh : '0);
                check("cfg", o_div_config,
                      (act && !m_bad() && m_t == 2) ? {m_div, 1'b1} : 9'h0);
                check("start_n", o_div_start_n,
                      !(act && !m_bad() && m_t == 3));
                check("err", o_err, (act && m_bad() && m_t == 2) ? oh : '0);
                check("done", o_done, m_fin ? oh : '0);
            end
        end
    end

    // Event monitor, sampled mid-cycle after the active edge.
    logic [N-1:0] gq[$];
    logic [N-1:0] dq[$];
    int done_cnt = 0;
    int err_cnt = 0;
    int start_cnt = 0;

    initial begin
        bit r_prev;
        r_prev = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (o_div_config[0]) gq.push_back(o_grant);
            if (o_done != '0) begin
                done_cnt++;
                dq.push_back(o_done);
                check("done_lat", r_prev, 0);
            end
            if (o_err != '0) err_cnt++;
            if (!o_div_start_n) start_cnt++;
            r_prev = ready;
        end
    end

    task automatic run_until_idle(input string nm);
        int k;
        k = 0;
        @(negedge clk);
        while (o_busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(nm, o_busy, 0);
    endtask

    task automatic wait_grant(input string nm);
        int k;
        k = 0;
        while (o_grant == '0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check(nm, o_grant != '0, 1);
    endtask

    task automatic wait_start(input string nm);
        int k;
        k = 0;
        while (o_div_start_n && k < 100) begin
            @(negedge clk);
            k++;
        end
        check(nm, o_div_start_n, 0);
    endtask

    function automatic logic [N-1:0] last_done();
        return (dq.size() > 0) ? dq[dq.size()-1] : '0;
    endfunction

    initial begin
        int s, d0, e0, st0, g0, k;
        rst_n = 1'b0;
        req = '0;
        div = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_grant", o_grant, 0);
        check("rst_done", o_done, 0);
        check("rst_err", o_err, 0);
        check("rst_busy", o_busy, 0);
        check("rst_cfg", o_div_config, 0);
        check("rst_start_n", o_div_start_n, 1);

        div = {8'd6, 8'd4};
        s = gq.size();
        d0 = done_cnt;
        req = 2'b11;
        k = 0;
        while (gq.size() < s + 4 && k < 400) begin
            @(negedge clk);
            k++;
        end
        req = '0;
        check("rr_grants", gq.size(), s + 4);
        run_until_idle("rr_idle");
        for (int i = 0; i < 4; i++)
            check("rr_order", (gq.size() > s + i) ? gq[s+i] : '0,
                  (i % 2 == 0) ? 1 : 2);
        check("rr_done", done_cnt - d0, 4);

        d0 = done_cnt;
        req = 2'b01;
        @(negedge clk);
        check("one_busy", o_busy, 1);
        check("one_nogrant", o_grant, 0);
        @(negedge clk);
        check("one_grant", o_grant, 2'b01);
        check("one_cfg", o_div_config, 9'h009);
        req = '0;
        @(negedge clk);
        check("one_start", o_div_start_n, 0);
        check("one_cfg_clr", o_div_config, 0);
        run_until_idle("one_idle");
        check("one_done", done_cnt - d0, 1);
        check("one_done_who", last_done(), 2'b01);

        d0 = done_cnt;
        div = {8'd6, 8'd8};
        req = 2'b01;
        wait_start("drop_start");
        repeat (4) @(negedge clk);
        check("drop_in_burst", o_busy, 1);
        req = '0;
        run_until_idle("drop_idle");
        check("drop_done", done_cnt - d0, 1);
        check("drop_done_who", last_done(), 2'b01);
        req = 2'b11;
        wait_grant("adv_wait");
        check("adv_grant", o_grant, 2'b10);
        req = '0;
        run_until_idle("adv_idle");

        for (int j = 0; j < 2; j++) begin
            e0 = err_cnt;
            st0 = start_cnt;
            g0 = gq.size();
            div = {8'd6, (j == 0) ? 8'd5 : 8'd0};
            req = 2'b01;
            @(negedge clk);
            req = '0;
            run_until_idle("bad_idle");
            check("bad_err", err_cnt - e0, (CHK == 1) ? 1 : 0);
            check("bad_start", start_cnt - st0, (CHK == 1) ? 0 : 1);
            check("bad_grant", gq.size() - g0, (CHK == 1) ? 0 : 1);
        end

        div = {8'd6, 8'd4};
        req = 2'b11;
        wait_start("rm_start");
        check("rm_owner", o_grant, 2'b10);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rm_grant", o_grant, 0);
        check("rm_done", o_done, 0);
        check("rm_busy", o_busy, 0);
        check("rm_cfg", o_div_config, 0);
        check("rm_start_n", o_div_start_n, 1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_grant("rm_regrant");
        check("rm_first", o_grant, 2'b01);
        req = '0;
        run_until_idle("rm_idle");
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
